// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU (alu_mc) and its shifter.
// Optional build macro used by this slice: ALU_MC_BARREL_EN.
package alu_mc_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    OP_ADD  = 3'b000,
    OP_LSL  = 3'b001,
    OP_MOVF = 3'b010,
    OP_XOR  = 3'b011,
    OP_MOVT = 3'b100,
    OP_LSR  = 3'b101,
    OP_SUB  = 3'b110,
    OP_CMP  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } alu_state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// Shift datapath for alu_mc: serial (one bit per cycle) by default, single-cycle
// barrel shifter when ALU_MC_BARREL_EN is defined. Owns the shift counter.
module alu_mc_shifter
  import alu_mc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         left_i,
  input  logic         step_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] amt_i,
  output logic [W-1:0] res_o,
  output logic         flag_o,
  output logic         shift_last_o
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d, amt_c;
  logic [W-1:0]  sh_q, sh_d;
  logic          fbit_q, fbit_d;
  logic          left_q, left_d;
  logic          over_q, over_d;
  logic          over_c;

  // Amounts beyond W shift out everything; only the flag differs from amount == W.
  assign over_c = (32'(amt_i) > W);
  assign amt_c  = over_c ? CW'(W) : CW'(amt_i);

`ifdef ALU_MC_BARREL_EN
  logic [2*W-1:0] lsl_t, lsr_t;

  always_comb begin
    lsl_t  = {{W{1'b0}}, a_i} << amt_c;
    lsr_t  = {a_i, {W{1'b0}}} >> amt_c;
    cnt_d  = '0;
    sh_d   = sh_q;
    fbit_d = fbit_q;
    left_d = left_q;
    over_d = 1'b0;
    if (load_i) begin
      sh_d   = left_i ? lsl_t[W-1:0] : lsr_t[2*W-1:W];
      fbit_d = (amt_c != '0) && !over_c && (left_i ? lsl_t[W] : lsr_t[W-1]);
      left_d = left_i;
    end
  end

  assign shift_last_o = 1'b0;
`else
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    fbit_d = fbit_q;
    left_d = left_q;
    over_d = over_q;
    if (load_i) begin
      cnt_d  = amt_c;
      sh_d   = a_i;
      fbit_d = 1'b0;
      left_d = left_i;
      over_d = over_c;
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
      if (left_q) begin
        fbit_d = sh_q[W-1];
        sh_d   = {sh_q[W-2:0], 1'b0};
      end else begin
        fbit_d = sh_q[0];
        sh_d   = {1'b0, sh_q[W-1:1]};
      end
    end
  end

  assign shift_last_o = (cnt_q == CW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      left_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      left_q <= left_d;
      over_q <= over_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    fbit_q <= fbit_d;
  end

  assign res_o  = sh_q;
  assign flag_o = fbit_q & ~over_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with start/done handshake, registered result/carry/zero.
// Define ALU_MC_BARREL_EN for single-cycle shifts; default is a serial shifter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  output logic             ready,
  output logic             done,
  output logic [W-1:0]     rslt,
  output logic             flag,
  output logic             zero
);

`ifdef ALU_MC_BARREL_EN
  localparam bit SerialShift = 1'b0;
`else
  localparam bit SerialShift = 1'b1;
`endif

  alu_state_t  state_q;
  logic        ready_q, done_q, flag_q, zero_q;
  logic [W-1:0] rslt_q;
  alu_op_t     op_i, cmd_q;
  logic [W-1:0] a_q, b_q;
  logic        accept;
  logic [W-1:0] sh_res, res_c;
  logic        sh_flag, shift_last, flag_c;

  assign op_i   = alu_op_t'(alu_cmd);
  assign accept = (state_q == ST_IDLE) && start;

  alu_mc_shifter #(.W(W)) u_shifter (
    .clk         (Clk),
    .rst         (Reset),
    .load_i      (accept && is_shift(op_i)),
    .left_i      (op_i == OP_LSL),
    .step_i      (state_q == ST_SHIFT),
    .a_i         (inA),
    .amt_i       (inB),
    .res_o       (sh_res),
    .flag_o      (sh_flag),
    .shift_last_o(shift_last)
  );

  always_ff @(posedge Clk) begin
    if (accept) begin
      cmd_q <= op_i;
      a_q   <= inA;
      b_q   <= inB;
    end
  end

  always_comb begin
    res_c  = '0;
    flag_c = 1'b0;
    case (cmd_q)
      OP_ADD:         {flag_c, res_c} = {1'b0, a_q} + {1'b0, b_q};
      OP_LSL, OP_LSR: begin
        res_c  = sh_res;
        flag_c = sh_flag;
      end
      OP_MOVF:        res_c = a_q;
      OP_XOR:         res_c = a_q ^ b_q;
      OP_MOVT:        res_c = b_q;
      OP_SUB: begin
        res_c  = a_q - b_q;
        flag_c = (b_q > a_q);
      end
      OP_CMP:         flag_c = (a_q == b_q);
      default:        res_c = '0;
    endcase
  end

  // Outputs only move on the edge that raises done; SHIFT is skipped for zero amounts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rslt_q  <= '0;
      flag_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ready_q <= 1'b0;
            state_q <= (SerialShift && is_shift(op_i) && (inB != '0)) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (shift_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          rslt_q  <= res_c;
          flag_q  <= flag_c;
          zero_q  <= (res_c == '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rslt  = rslt_q;
  assign flag  = flag_q;
  assign zero  = zero_q;

endmodule
